// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for the immediate-generation stage: an instruction channel in,
// a decoded-result channel out. The stage itself connects through the slave modport.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_type;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_pc, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generation stage: decodes the instruction format, builds the
// XLEN-wide immediate and holds results in a 1-entry register or a 2-entry skid buffer.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus,
    output logic [7:0]    err_count
);
    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_Z   = 3'd6,
        FMT_BAD = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    logic [31:0]     inst;
    fmt_e            dec_type;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;

    logic            accept;
    logic            load_main;
    logic            load_skid;
    logic            shift_skid;
    logic            main_valid;

    logic [XLEN-1:0] main_imm;
    logic [XLEN-1:0] main_pc;
    logic [2:0]      main_type;
    logic [XLEN-1:0] skid_imm;
    logic [XLEN-1:0] skid_pc;
    logic [2:0]      skid_type;

    assign inst   = bus.in_inst;
    assign accept = bus.in_valid && bus.in_ready;

    // imm32 is already sign-extended to 32 bits (Z is zero-extended), so widening
    // to XLEN only needs to replicate bit 31.
    always_comb begin
        dec_type = FMT_BAD;
        imm32    = '0;
        case (inst[6:0])
            7'b0110011: dec_type = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111: begin
                dec_type = FMT_I;
                imm32    = {{20{inst[31]}}, inst[31:20]};
            end
            7'b1110011: begin
                if (inst[14]) begin
                    dec_type = FMT_Z;
                    imm32    = {27'd0, inst[19:15]};
                end else begin
                    dec_type = FMT_I;
                    imm32    = {{20{inst[31]}}, inst[31:20]};
                end
            end
            7'b0100011: begin
                dec_type = FMT_S;
                imm32    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                dec_type = FMT_B;
                imm32    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_type = FMT_U;
                imm32    = {inst[31:12], 12'h000};
            end
            7'b1101111: begin
                dec_type = FMT_J;
                imm32    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: dec_type = FMT_BAD;
        endcase
        dec_imm        = {XLEN{imm32[31]}};
        dec_imm[31:0]  = imm32;
    end

    generate
        if (DEPTH == 2) begin : g_skid
            state_e state;
            state_e state_next;

            // State register; flush is folded into the next-state logic.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= EMPTY;
                end else begin
                    state <= state_next;
                end
            end

            always_comb begin
                state_next = state;
                load_main  = 1'b0;
                load_skid  = 1'b0;
                shift_skid = 1'b0;
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            state_next = ONE;
                            load_main  = 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && bus.out_ready) begin
                            load_main = 1'b1;
                        end else if (accept) begin
                            state_next = FULL;
                            load_skid  = 1'b1;
                        end else if (bus.out_ready) begin
                            state_next = EMPTY;
                        end
                    end
                    FULL: begin
                        if (bus.out_ready) begin
                            state_next = ONE;
                            shift_skid = 1'b1;
                        end
                    end
                    default: state_next = EMPTY;
                endcase
                if (flush) begin
                    state_next = EMPTY;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    skid_imm  <= '0;
                    skid_pc   <= '0;
                    skid_type <= '0;
                end else if (load_skid) begin
                    skid_imm  <= dec_imm;
                    skid_pc   <= bus.in_pc;
                    skid_type <= dec_type;
                end
            end

            // in_ready comes straight from the state register, not from out_ready.
            assign main_valid   = (state != EMPTY);
            assign bus.in_ready = !flush && (state != FULL);
        end else begin : g_single
            assign load_main  = accept;
            assign load_skid  = 1'b0;
            assign shift_skid = 1'b0;
            assign skid_imm   = '0;
            assign skid_pc    = '0;
            assign skid_type  = '0;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                end else if (bus.out_ready) begin
                    main_valid <= 1'b0;
                end
            end

            assign bus.in_ready = !flush && (!main_valid || bus.out_ready);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_imm  <= '0;
            main_pc   <= '0;
            main_type <= '0;
        end else if (load_main) begin
            main_imm  <= dec_imm;
            main_pc   <= bus.in_pc;
            main_type <= dec_type;
        end else if (shift_skid) begin
            main_imm  <= skid_imm;
            main_pc   <= skid_pc;
            main_type <= skid_type;
        end
    end

    // Survives flush on purpose: it is a diagnostic of the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (accept && (dec_type == FMT_BAD) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

    assign bus.out_valid   = main_valid;
    assign bus.out_imm     = main_imm;
    assign bus.out_type    = main_type;
    assign bus.out_pc      = main_pc;
    assign bus.out_illegal = (main_type == 3'd7);
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Drives a DEPTH=1/XLEN=32 and a DEPTH=2/XLEN=64 instance with the same stimulus and
// checks both against a queue-based reference model of the stage.
module tb_imm_gen_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [7:0] err1;
    logic [7:0] err2;

    imm_gen_pipe_if #(.XLEN(32)) bus1 ();
    imm_gen_pipe_if #(.XLEN(64)) bus2 ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus1),
        .err_count (err1)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus2),
        .err_count (err2)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint imm;
        int     typ;
        longint pc;
    } ent_t;

    ent_t q1[$];
    ent_t q2[$];
    int   e1 = 0;
    int   e2 = 0;
    int   compareCount = 0;
    int   failCount = 0;

    localparam logic [63:0] MASK32 = 64'h0000_0000_FFFF_FFFF;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compareCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Immediates assembled with shifts and weighted field sums on 64-bit signed values.
    function automatic void refDecode(input logic [31:0] inst, output int typ, output longint imm);
        longint s;
        longint u;
        s   = longint'(int'(inst));
        u   = longint'(inst);
        typ = 7;
        imm = 0;
        case (inst[6:0])
            7'h33: typ = 0;
            7'h13, 7'h03, 7'h67, 7'h0F: begin typ = 1; imm = s >>> 20; end
            7'h73: begin
                if (inst[14]) begin typ = 6; imm = (u >> 15) & 31; end
                else begin typ = 1; imm = s >>> 20; end
            end
            7'h23: begin typ = 2; imm = (s >>> 25) * 32 + ((u >> 7) & 31); end
            7'h63: begin
                typ = 3;
                imm = (s >>> 31) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32 + ((u >> 8) & 15) * 2;
            end
            7'h37, 7'h17: begin typ = 4; imm = (s >>> 12) * 4096; end
            7'h6F: begin
                typ = 5;
                imm = (s >>> 31) * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048 + ((u >> 21) & 1023) * 2;
            end
            default: typ = 7;
        endcase
    endfunction

    function automatic logic [31:0] randInst();
        logic [6:0]  ops [11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) != 0) begin
            r[6:0] = ops[$urandom_range(0, 10)];
        end
        return r;
    endfunction

    // One cycle: drive inputs after the falling edge, check, then advance the model on the rising edge.
    task automatic applyStimulus(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                                 input bit ordy, input bit fl);
        bit     r1;
        bit     r2;
        int     ty;
        longint im;
        ent_t   e;
        bus1.in_valid  = v;
        bus2.in_valid  = v;
        bus1.in_inst   = inst;
        bus2.in_inst   = inst;
        bus1.in_pc     = pc[31:0];
        bus2.in_pc     = pc;
        bus1.out_ready = ordy;
        bus2.out_ready = ordy;
        flush          = fl;
        #1;
        r1 = !fl && (q1.size() == 0 || ordy);
        r2 = !fl && (q2.size() < 2);
        checkOutput("d1_in_ready", 64'(bus1.in_ready), 64'(r1));
        checkOutput("d2_in_ready", 64'(bus2.in_ready), 64'(r2));
        checkOutput("d1_out_valid", 64'(bus1.out_valid), 64'(q1.size() != 0));
        checkOutput("d2_out_valid", 64'(bus2.out_valid), 64'(q2.size() != 0));
        if (q1.size() != 0) begin
            checkOutput("d1_imm", 64'(bus1.out_imm), q1[0].imm & MASK32);
            checkOutput("d1_type", 64'(bus1.out_type), 64'(q1[0].typ));
            checkOutput("d1_pc", 64'(bus1.out_pc), q1[0].pc);
            checkOutput("d1_illegal", 64'(bus1.out_illegal), 64'(q1[0].typ == 7));
        end
        if (q2.size() != 0) begin
            checkOutput("d2_imm", bus2.out_imm, q2[0].imm);
            checkOutput("d2_type", 64'(bus2.out_type), 64'(q2[0].typ));
            checkOutput("d2_pc", bus2.out_pc, q2[0].pc);
            checkOutput("d2_illegal", 64'(bus2.out_illegal), 64'(q2[0].typ == 7));
        end
        checkOutput("d1_err", 64'(err1), 64'(e1));
        checkOutput("d2_err", 64'(err2), 64'(e2));
        refDecode(inst, ty, im);
        e.typ = ty;
        e.imm = im;
        @(posedge clk);
        if (fl) begin
            q1.delete();
            q2.delete();
        end else begin
            if (q1.size() != 0 && ordy) void'(q1.pop_front());
            if (q2.size() != 0 && ordy) void'(q2.pop_front());
            if (v && r1) begin
                e.pc = longint'(pc & MASK32);
                q1.push_back(e);
                if (ty == 7 && e1 < 255) e1++;
            end
            if (v && r2) begin
                e.pc = longint'(pc);
                q2.push_back(e);
                if (ty == 7 && e2 < 255) e2++;
            end
        end
        @(negedge clk);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_d1_valid"}, 64'(bus1.out_valid), 64'd0);
        checkOutput({tag, "_d2_valid"}, 64'(bus2.out_valid), 64'd0);
        checkOutput({tag, "_d1_imm"}, 64'(bus1.out_imm), 64'd0);
        checkOutput({tag, "_d2_imm"}, bus2.out_imm, 64'd0);
        checkOutput({tag, "_d1_type"}, 64'(bus1.out_type), 64'd0);
        checkOutput({tag, "_d2_pc"}, bus2.out_pc, 64'd0);
        checkOutput({tag, "_d1_illegal"}, 64'(bus1.out_illegal), 64'd0);
        checkOutput({tag, "_d1_err"}, 64'(err1), 64'd0);
        checkOutput({tag, "_d2_err"}, 64'(err2), 64'd0);
        checkOutput({tag, "_d1_ready"}, 64'(bus1.in_ready), 64'd1);
        checkOutput({tag, "_d2_ready"}, 64'(bus2.in_ready), 64'd1);
    endtask

    initial begin
        rst_n          = 1'b1;
        flush          = 1'b0;
        bus1.in_valid  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus1.in_inst   = '0;
        bus2.in_inst   = '0;
        bus1.in_pc     = '0;
        bus2.in_pc     = '0;
        bus1.out_ready = 1'b0;
        bus2.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkCleared("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed decode cases");
        applyStimulus(1, 32'hFFF00093, 64'h100, 1, 0);
        checkOutput("addi_type", 64'(bus1.out_type), 64'd1);
        checkOutput("addi_imm32", 64'(bus1.out_imm), 64'hFFFF_FFFF);
        checkOutput("addi_imm64", bus2.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("addi_illegal", 64'(bus1.out_illegal), 64'd0);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);

        applyStimulus(1, 32'hFE112E23, 64'h104, 1, 0);
        checkOutput("sw_type", 64'(bus1.out_type), 64'd2);
        checkOutput("sw_imm", 64'(bus1.out_imm), 64'hFFFF_FFFC);
        applyStimulus(1, 32'hFE000CE3, 64'h108, 1, 0);
        checkOutput("beq_type", 64'(bus1.out_type), 64'd3);
        checkOutput("beq_imm", 64'(bus1.out_imm), 64'hFFFF_FFF8);
        checkOutput("beq_valid_d2", 64'(bus2.out_valid), 64'd1);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);

        applyStimulus(1, 32'h800000B7, 64'h10C, 1, 0);
        checkOutput("lui_imm32", 64'(bus1.out_imm), 64'h8000_0000);
        checkOutput("lui_imm64", bus2.out_imm, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(1, 32'h300FD073, 64'h110, 1, 0);
        checkOutput("csrrwi_type", 64'(bus2.out_type), 64'd6);
        checkOutput("csrrwi_imm", bus2.out_imm, 64'h1F);
        applyStimulus(1, 32'h00000000, 64'h114, 1, 0);
        checkOutput("bad_type", 64'(bus1.out_type), 64'd7);
        checkOutput("bad_imm", 64'(bus1.out_imm), 64'd0);
        checkOutput("bad_illegal", 64'(bus1.out_illegal), 64'd1);
        checkOutput("bad_err", 64'(err1), 64'd1);
        for (int i = 0; i < 299; i++) begin
            applyStimulus(1, 32'h00000000, 64'(i), 1, 0);
        end
        checkOutput("err_sat_d1", 64'(err1), 64'hFF);
        checkOutput("err_sat_d2", 64'(err2), 64'hFF);
        applyStimulus(1, 32'h0000_0001, 64'h0, 1, 0);
        checkOutput("err_hold", 64'(err2), 64'hFF);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);

        $display("[TB] skid stream, flush and reset");
        applyStimulus(1, 32'h00A00093, 64'hA00, 0, 0);
        applyStimulus(1, 32'h00B00093, 64'hB00, 0, 0);
        checkOutput("skid_full_ready", 64'(bus2.in_ready), 64'd0);
        applyStimulus(1, 32'h00C00093, 64'hC00, 0, 0);
        applyStimulus(1, 32'h00C00093, 64'hC00, 1, 0);
        checkOutput("drain_head_b", bus2.out_pc, 64'hB00);
        applyStimulus(1, 32'h00C00093, 64'hC00, 1, 0);
        checkOutput("drain_head_c", bus2.out_pc, 64'hC00);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);
        applyStimulus(0, 32'h0, 64'h0, 1, 0);

        applyStimulus(1, 32'h123450B7, 64'hD00, 0, 0);
        applyStimulus(1, 32'h0040006F, 64'hD04, 0, 0);
        applyStimulus(1, 32'h00000013, 64'hD08, 0, 1);
        checkOutput("flush_empty_d2", 64'(bus2.out_valid), 64'd0);
        checkOutput("flush_empty_d1", 64'(bus1.out_valid), 64'd0);
        checkOutput("flush_err_kept", 64'(err2), 64'hFF);

        applyStimulus(1, 32'hFFF00093, 64'hE00, 0, 0);
        applyStimulus(1, 32'h00000000, 64'hE04, 0, 0);
        rst_n = 1'b0;
        #1 checkCleared("midreset");
        q1.delete();
        q2.delete();
        e1 = 0;
        e2 = 0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, randInst(), {$urandom, $urandom},
                          $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end
endmodule
